// File: rtl/rx_link_pkg.sv
// rx_link_pkg: shared state type, sync-header codes and default parameters
// for the 10GBASE-R receive link controller.
package rx_link_pkg;

   typedef enum logic [1:0] {
      HUNT,
      SLIP,
      WAIT,
      LOCKED
   } link_state_e;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam int LOCK_CNT_DEF    = 64;
   localparam int INVALID_MAX_DEF = 16;
   localparam int SLIP_WAIT_DEF   = 32;
   localparam int BER_WINDOW_DEF  = 39062;
   localparam int BER_MAX_DEF     = 16;

   function automatic logic sh_is_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage

// File: rtl/rx_link_ctrl_if.sv
// rx_link_ctrl_if: gearbox-side header inputs and link status outputs of rx_link_ctrl.
interface rx_link_ctrl_if;

   logic [1:0]  head_i;
   logic        head_valid_i;
   logic        decode_error_i;
   logic        slip_o;
   logic        block_lock_o;
   logic        hi_ber_o;
   logic        dp_rst_o;
   logic [5:0]  ber_cnt_o;
   logic [15:0] err_cnt_o;

   modport master (
      output head_i, head_valid_i, decode_error_i,
      input  slip_o, block_lock_o, hi_ber_o, dp_rst_o, ber_cnt_o, err_cnt_o
   );

   modport slave (
      input  head_i, head_valid_i, decode_error_i,
      output slip_o, block_lock_o, hi_ber_o, dp_rst_o, ber_cnt_o, err_cnt_o
   );

endinterface

// File: rtl/rx_ber_mon.sv
// rx_ber_mon: free-running BER window timer with saturating invalid-header count
// and hi_ber flag; count and flag are held clear whenever i_lock is low.
module rx_ber_mon #(
   parameter int BER_WINDOW = 39062,
   parameter int BER_MAX    = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       i_lock,
   input  logic       i_inv,
   output logic       o_hi_ber,
   output logic [5:0] o_ber_cnt
);

   localparam int TW = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(BER_WINDOW - 1);
   localparam logic [5:0]    BER_SAT    = 6'(BER_MAX);

   logic [TW-1:0] r_timer;
   logic [5:0]    r_ber_cnt;
   logic          r_hi_ber;
   logic          w_wrap;

   assign w_wrap = (r_timer == TIMER_LAST);

   // The timer never stops, so window boundaries are independent of lock history.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       r_timer <= '0;
      else if (w_wrap) r_timer <= '0;
      else             r_timer <= r_timer + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ber_cnt <= '0;
         r_hi_ber  <= 1'b0;
      end else if (!i_lock) begin
         r_ber_cnt <= '0;
         r_hi_ber  <= 1'b0;
      end else if (w_wrap) begin
         r_ber_cnt <= {5'd0, i_inv};
         r_hi_ber  <= (r_ber_cnt == BER_SAT);
      end else begin
         if (i_inv && (r_ber_cnt < BER_SAT)) r_ber_cnt <= r_ber_cnt + 1'b1;
         if (r_ber_cnt == BER_SAT)           r_hi_ber  <= 1'b1;
      end
   end

   assign o_hi_ber  = r_hi_ber;
   assign o_ber_cnt = r_ber_cnt;

endmodule

// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: block-lock FSM driving gearbox slip, datapath reset and BER monitor.
// Define RX_LINK_ERR_CNT_EN to build the decode error counter behind err_cnt_o.
module rx_link_ctrl
   import rx_link_pkg::*;
#(
   parameter int LOCK_CNT    = LOCK_CNT_DEF,
   parameter int INVALID_MAX = INVALID_MAX_DEF,
   parameter int SLIP_WAIT   = SLIP_WAIT_DEF,
   parameter int BER_WINDOW  = BER_WINDOW_DEF,
   parameter int BER_MAX     = BER_MAX_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   rx_link_ctrl_if.slave link
);

   localparam int SW = $clog2(LOCK_CNT + 1);
   localparam int IW = $clog2(INVALID_MAX + 1);
   localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
   localparam logic [SW-1:0] SH_LAST   = SW'(LOCK_CNT - 1);
   localparam logic [SW-1:0] WIN_FULL  = SW'(LOCK_CNT);
   localparam logic [IW-1:0] INV_FULL  = IW'(INVALID_MAX);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

   link_state_e   r_state, w_state_nxt;
   logic [SW-1:0] r_sh_cnt, w_sh_nxt;
   logic [SW-1:0] r_win_cnt, w_win_nxt, w_win_inc;
   logic [IW-1:0] r_inv_cnt, w_inv_nxt, w_inv_inc;
   logic [WW-1:0] r_wait_cnt, w_wait_nxt;
   logic          w_hdr_ok, w_hdr_bad, w_lock_nxt;
   logic          r_block_lock, r_slip, r_dp_rst;
   logic          w_hi_ber;
   logic [5:0]    w_ber_cnt;

   assign w_hdr_ok   = link.head_valid_i &  sh_is_valid(link.head_i);
   assign w_hdr_bad  = link.head_valid_i & ~sh_is_valid(link.head_i);
   assign w_win_inc  = r_win_cnt + 1'b1;
   assign w_inv_inc  = r_inv_cnt + IW'(w_hdr_bad);
   assign w_lock_nxt = (w_state_nxt == LOCKED);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh_cnt;
      w_win_nxt   = r_win_cnt;
      w_inv_nxt   = r_inv_cnt;
      w_wait_nxt  = r_wait_cnt;
      case (r_state)
         HUNT: begin
            if (w_hdr_bad) begin
               w_sh_nxt    = '0;
               w_state_nxt = SLIP;
            end else if (w_hdr_ok) begin
               if (r_sh_cnt == SH_LAST) begin
                  w_sh_nxt    = '0;
                  w_win_nxt   = '0;
                  w_inv_nxt   = '0;
                  w_state_nxt = LOCKED;
               end else begin
                  w_sh_nxt = r_sh_cnt + 1'b1;
               end
            end
         end
         SLIP: begin
            w_wait_nxt  = '0;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (r_wait_cnt == WAIT_LAST) begin
               w_wait_nxt  = '0;
               w_sh_nxt    = '0;
               w_state_nxt = HUNT;
            end else begin
               w_wait_nxt = r_wait_cnt + 1'b1;
            end
         end
         LOCKED: begin
            // Loss of lock is tested before window end so it wins on the last header.
            if (link.head_valid_i) begin
               if (w_inv_inc == INV_FULL) begin
                  w_win_nxt   = '0;
                  w_inv_nxt   = '0;
                  w_state_nxt = SLIP;
               end else if (w_win_inc == WIN_FULL) begin
                  w_win_nxt = '0;
                  w_inv_nxt = '0;
               end else begin
                  w_win_nxt = w_win_inc;
                  w_inv_nxt = w_inv_inc;
               end
            end
         end
         default: w_state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= HUNT;
         r_sh_cnt     <= '0;
         r_win_cnt    <= '0;
         r_inv_cnt    <= '0;
         r_wait_cnt   <= '0;
         r_block_lock <= 1'b0;
         r_slip       <= 1'b0;
         r_dp_rst     <= 1'b1;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         r_state      <= w_state_nxt;
         r_sh_cnt     <= w_sh_nxt;
         r_win_cnt    <= w_win_nxt;
         r_inv_cnt    <= w_inv_nxt;
         r_wait_cnt   <= w_wait_nxt;
         r_block_lock <= w_lock_nxt;
         r_slip       <= (w_state_nxt == SLIP);
         r_dp_rst     <= ~r_block_lock;
      end
   end

   rx_ber_mon #(
      .BER_WINDOW (BER_WINDOW),
      .BER_MAX    (BER_MAX)
   ) u_ber_mon (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_lock    (w_lock_nxt),
      .i_inv     (w_hdr_bad),
      .o_hi_ber  (w_hi_ber),
      .o_ber_cnt (w_ber_cnt)
   );

`ifdef RX_LINK_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_err_cnt <= '0;
      else if (w_lock_nxt && !r_block_lock)
         r_err_cnt <= '0;
      else if (r_block_lock && link.decode_error_i && (r_err_cnt != 16'hFFFF))
         r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign link.err_cnt_o = r_err_cnt;
`else
   logic w_unused_err;
   assign w_unused_err   = link.decode_error_i;
   assign link.err_cnt_o = 16'd0;
`endif

   assign link.slip_o       = r_slip;
   assign link.block_lock_o = r_block_lock;
   assign link.dp_rst_o     = r_dp_rst;
   assign link.hi_ber_o     = w_hi_ber;
   assign link.ber_cnt_o    = w_ber_cnt;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb_rx_link_ctrl: directed scenarios plus randomized header streams checked every
// cycle against a behavioural link model; BER window shortened to keep runs brief.
module tb_rx_link_ctrl;

   localparam int LOCK_CNT    = 64;
   localparam int INVALID_MAX = 16;
   localparam int SLIP_WAIT   = 32;
   localparam int BER_WINDOW  = 2000;
   localparam int BER_MAX     = 16;
`ifdef RX_LINK_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int PCTS [6] = '{0, 1, 3, 8, 25, 60};

   logic clk_i;
   logic rst_i;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Behavioural model state
   bit m_lock, m_hi, m_dp_rst;
   int m_run, m_quiet, m_win, m_bad, m_ber, m_tpos, m_err;

   rx_link_ctrl_if u_if ();

   rx_link_ctrl #(
      .LOCK_CNT    (LOCK_CNT),
      .INVALID_MAX (INVALID_MAX),
      .SLIP_WAIT   (SLIP_WAIT),
      .BER_WINDOW  (BER_WINDOW),
      .BER_MAX     (BER_MAX)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .link  (u_if)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_lock = 0; m_hi = 0; m_dp_rst = 1;
      m_run = 0; m_quiet = 0; m_win = 0; m_bad = 0; m_ber = 0; m_tpos = 0; m_err = 0;
   endfunction

   // One clock edge of the link rules, applied to the inputs seen before the edge.
   function automatic void model_step(input logic [1:0] h, input logic hv, input logic de);
      bit valid, bad, wrap, was_locked;
      valid      = hv && (h == 2'b01 || h == 2'b10);
      bad        = hv && !valid;
      wrap       = (m_tpos == BER_WINDOW - 1);
      was_locked = m_lock;
      m_dp_rst   = !was_locked;
      if (ERR_EN && was_locked && de && m_err < 65535) m_err++;
      if (m_quiet > 0) begin
         m_quiet--;
      end else if (!m_lock) begin
         if (bad) begin
            m_run = 0;
            m_quiet = SLIP_WAIT + 1;
         end else if (valid) begin
            m_run++;
            if (m_run == LOCK_CNT) begin
               m_lock = 1; m_run = 0; m_win = 0; m_bad = 0;
               if (ERR_EN) m_err = 0;
            end
         end
      end else if (hv) begin
         m_win++;
         if (bad) m_bad++;
         if (m_bad == INVALID_MAX) begin
            m_lock = 0; m_run = 0; m_win = 0; m_bad = 0;
            m_quiet = SLIP_WAIT + 1;
         end else if (m_win == LOCK_CNT) begin
            m_win = 0; m_bad = 0;
         end
      end
      if (!m_lock) begin
         m_ber = 0; m_hi = 0;
      end else if (wrap) begin
         m_hi  = (m_ber == BER_MAX);
         m_ber = bad ? 1 : 0;
      end else begin
         if (m_ber == BER_MAX) m_hi = 1;
         if (bad && m_ber < BER_MAX) m_ber++;
      end
      m_tpos = wrap ? 0 : m_tpos + 1;
   endfunction

   always @(posedge clk_i) begin
      if (!rst_i) begin
         model_step(u_if.head_i, u_if.head_valid_i, u_if.decode_error_i);
         #1;
         check("cyc_slip",  32'(u_if.slip_o),       32'(m_quiet == SLIP_WAIT + 1));
         check("cyc_lock",  32'(u_if.block_lock_o), 32'(m_lock));
         check("cyc_hiber", 32'(u_if.hi_ber_o),     32'(m_hi));
         check("cyc_dprst", 32'(u_if.dp_rst_o),     32'(m_dp_rst));
         check("cyc_bercnt",32'(u_if.ber_cnt_o),    32'(m_ber));
         check("cyc_errcnt",32'(u_if.err_cnt_o),    32'(m_err));
      end
   end

   task automatic drive(input logic [1:0] h, input logic hv, input logic de);
      @(negedge clk_i);
      u_if.head_i = h; u_if.head_valid_i = hv; u_if.decode_error_i = de;
      @(posedge clk_i);
      #2;
   endtask

   task automatic hdr(input logic [1:0] h);
      drive(h, 1'b1, 1'b0);
      drive(2'b00, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_slip"},  32'(u_if.slip_o),       32'd0);
      check({tag, "_lock"},  32'(u_if.block_lock_o), 32'd0);
      check({tag, "_hiber"}, 32'(u_if.hi_ber_o),     32'd0);
      check({tag, "_dprst"}, 32'(u_if.dp_rst_o),     32'd1);
      check({tag, "_ber"},   32'(u_if.ber_cnt_o),    32'd0);
      check({tag, "_err"},   32'(u_if.err_cnt_o),    32'd0);
   endtask

   task automatic async_reset();
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      #1 rst_i = 1'b0;
   endtask

   task automatic wait_wrap();
      for (int k = 0; k < BER_WINDOW + 4 && m_tpos != 0; k++) idle(1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached after %0d tests", n_tests);
      $fatal(1, "simulation time limit");
   end

   initial begin
      bit reslip;
      rst_i = 1'b1;
      u_if.head_i = 2'b00; u_if.head_valid_i = 1'b0; u_if.decode_error_i = 1'b0;
      model_reset();
      #11 check_reset_outputs("por");
      #1 rst_i = 1'b0;

      // Clean lock on alternating data/control headers
      for (int i = 0; i < LOCK_CNT - 1; i++) hdr(i[0] ? 2'b10 : 2'b01);
      check("lock_before_64th", 32'(u_if.block_lock_o), 32'd0);
      drive(2'b10, 1'b1, 1'b0);
      check("lock_at_64th", 32'(u_if.block_lock_o), 32'd1);
      check("dprst_same_edge", 32'(u_if.dp_rst_o), 32'd1);
      idle(1);
      check("dprst_next_edge", 32'(u_if.dp_rst_o), 32'd0);

      // Loss of lock on 16 invalid headers
      for (int i = 0; i < INVALID_MAX - 1; i++) hdr(2'b00);
      check("loss_15_lock", 32'(u_if.block_lock_o), 32'd1);
      check("loss_15_ber",  32'(u_if.ber_cnt_o), 32'd15);
      drive(2'b11, 1'b1, 1'b0);
      check("loss_16_lock", 32'(u_if.block_lock_o), 32'd0);
      check("loss_16_slip", 32'(u_if.slip_o), 32'd1);
      idle(1);
      check("loss_dprst", 32'(u_if.dp_rst_o), 32'd1);
      idle(SLIP_WAIT + 1);

      // Relock, then two windows holding only 15 invalid headers each
      for (int i = 0; i < LOCK_CNT; i++) hdr(2'b01);
      check("relock", 32'(u_if.block_lock_o), 32'd1);
      for (int i = 0; i < LOCK_CNT; i++) hdr((i % 4 == 0 && i < 60) ? 2'b11 : 2'b10);
      check("win15_a_lock", 32'(u_if.block_lock_o), 32'd1);
      check("win15_a_ber",  32'(u_if.ber_cnt_o), 32'd15);
      check("win15_a_hi",   32'(u_if.hi_ber_o), 32'd0);
      for (int i = 0; i < LOCK_CNT; i++) hdr((i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
      check("win15_b_lock", 32'(u_if.block_lock_o), 32'd1);
      check("ber_saturate", 32'(u_if.ber_cnt_o), 32'd16);
      check("ber_hi_set",   32'(u_if.hi_ber_o), 32'd1);

      // Async reset while locked, then a misaligned start
      async_reset();
      for (int i = 0; i < 4; i++) hdr(2'b01);
      drive(2'b11, 1'b1, 1'b0);
      check("misalign_slip", 32'(u_if.slip_o), 32'd1);
      reslip = 1'b0;
      for (int i = 0; i < SLIP_WAIT + 1; i++) begin
         drive(2'b00, 1'b1, 1'b0);
         reslip |= u_if.slip_o;
      end
      check("wait_ignores_hdrs", 32'(reslip), 32'd0);
      for (int i = 0; i < LOCK_CNT - 1; i++) hdr(i[0] ? 2'b10 : 2'b01);
      check("misalign_63", 32'(u_if.block_lock_o), 32'd0);
      hdr(2'b01);
      check("misalign_lock", 32'(u_if.block_lock_o), 32'd1);

      // BER: 4 invalid headers in each of 4 link windows inside one BER window
      wait_wrap();
      for (int w = 0; w < 4; w++)
         for (int j = 0; j < LOCK_CNT; j++) hdr(j < 4 ? 2'b00 : 2'b10);
      check("ber4x4_lock", 32'(u_if.block_lock_o), 32'd1);
      check("ber4x4_hi",   32'(u_if.hi_ber_o), 32'd1);
      check("ber4x4_cnt",  32'(u_if.ber_cnt_o), 32'd16);
      for (int i = 0; i < 3; i++) hdr(2'b11);
      check("ber_sat_hold", 32'(u_if.ber_cnt_o), 32'd16);
      wait_wrap();
      check("wrap_keep_hi", 32'(u_if.hi_ber_o), 32'd1);
      check("wrap_clr_cnt", 32'(u_if.ber_cnt_o), 32'd0);
      for (int i = 0; i < 3; i++) hdr(2'b00);
      check("win3_cnt", 32'(u_if.ber_cnt_o), 32'd3);
      check("win3_hi",  32'(u_if.hi_ber_o), 32'd1);
      wait_wrap();
      check("wrap_clr_hi", 32'(u_if.hi_ber_o), 32'd0);

      // Decode error counter
      for (int i = 0; i < 5; i++) drive(2'b00, 1'b0, 1'b1);
      idle(1);
      check("err_locked", 32'(u_if.err_cnt_o), ERR_EN ? 32'd5 : 32'd0);
      for (int i = 0; i < INVALID_MAX; i++) hdr(2'b11);
      check("err_loss_lock", 32'(u_if.block_lock_o), 32'd0);
      drive(2'b00, 1'b0, 1'b1);
      idle(1);
      check("err_unlocked", 32'(u_if.err_cnt_o), ERR_EN ? 32'd5 : 32'd0);
      idle(SLIP_WAIT + 4);
      for (int i = 0; i < LOCK_CNT; i++) hdr(2'b01);
      check("err_relock_lock", 32'(u_if.block_lock_o), 32'd1);
      check("err_relock_clr",  32'(u_if.err_cnt_o), 32'd0);

      // Randomized header streams at assorted error rates
      for (int seg = 0; seg < 12; seg++) begin
         int pct;
         pct = PCTS[seg % 6];
         if ($urandom_range(3) == 0) async_reset();
         for (int c = 0; c < 1500; c++) begin
            logic hv, de;
            logic [1:0] h;
            hv = seg[0] ? ($urandom_range(99) < 60) : c[0];
            if ($urandom_range(99) < pct) h = $urandom_range(1) ? 2'b11 : 2'b00;
            else                          h = $urandom_range(1) ? 2'b10 : 2'b01;
            de = ($urandom_range(99) < 5);
            drive(h, hv, de);
         end
      end

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
